// File: rtl/contador_arbitro.sv
// contador_arbitro
// Round-robin arbiter and sequencer for the shared WIDTH-bit ripple counter.
// It grants one of two requesters exclusive use of the counter, clears it,
// enables counting for the requested number of cycles, then pulses done.
//
// Ports:
//   clk        system clock (the counter advances on its falling edge)
//   clr        asynchronous active-high reset
//   req[1:0]   level request per requester
//   dur0/dur1  interval length per requester, sampled at grant
//   gnt[1:0]   one-hot owner, 0 when idle
//   done[1:0]  one-cycle completion pulse to the owner
//   abort      one-cycle pulse when the owner abandons its interval
//   busy       high whenever not idle
//   cnt_en     counter enable
//   cnt_clr_n  counter clear, active low
//   cnt_q      counter value

// Protocol checker; assertions only, no logic.
module contador_arbitro_chk (
  input logic       clk,
  input logic       clr,
  input logic [1:0] gnt,
  input logic [1:0] done,
  input logic       abort,
  input logic       busy,
  input logic       cnt_en,
  input logic       cnt_clr_n
);

  a_gnt_onehot : assert property (@(posedge clk) disable iff (clr)
    $onehot0(gnt));

  a_done_owner : assert property (@(posedge clk) disable iff (clr)
    (done != 2'b00) |-> (done == gnt));

  a_en_busy : assert property (@(posedge clk) disable iff (clr)
    cnt_en |-> (busy && cnt_clr_n));

  a_abort_idle : assert property (@(posedge clk) disable iff (clr)
    abort |-> !busy);

  a_idle_nognt : assert property (@(posedge clk) disable iff (clr)
    !busy |-> (gnt == 2'b00));

endmodule

module contador_arbitro #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] dur0,
  input  logic [WIDTH-1:0] dur1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             abort,
  output logic             busy,
  output logic             cnt_en,
  output logic             cnt_clr_n,
  input  logic [WIDTH-1:0] cnt_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic             last_r;     // most recently granted index, also the owner
  logic [WIDTH-1:0] dur_l_r;
  logic [1:0]       gnt_r;
  logic [1:0]       done_r;
  logic             abort_r;
  logic             busy_r;
  logic             cnt_en_r;
  logic             cnt_clr_n_r;

  logic             win_s;
  logic [WIDTH-1:0] win_dur_s;
  logic             owner_req_s;

  // Round-robin winner selection: on a tie the index other than last wins.
  always_comb begin
    win_s = last_r;
    case (req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ~last_r;
      default: win_s = last_r;
    endcase
    win_dur_s   = win_s ? dur1 : dur0;
    owner_req_s = req[last_r];
  end

  // Sequencer FSM; outputs are registered alongside the state they decode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      dur_l_r     <= {WIDTH{1'b0}};
      gnt_r       <= 2'b00;
      done_r      <= 2'b00;
      abort_r     <= 1'b0;
      busy_r      <= 1'b0;
      cnt_en_r    <= 1'b0;
      cnt_clr_n_r <= 1'b0;  // hold the counter cleared while in reset
    end else begin
      done_r  <= 2'b00;
      abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_en_r <= 1'b0;
          if (req != 2'b00) begin
            state_r     <= CLEAR;
            last_r      <= win_s;
            dur_l_r     <= win_dur_s;
            gnt_r       <= win_s ? 2'b10 : 2'b01;
            busy_r      <= 1'b1;
            cnt_clr_n_r <= 1'b0;
          end else begin
            state_r     <= IDLE;
            gnt_r       <= 2'b00;
            busy_r      <= 1'b0;
            cnt_clr_n_r <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_clr_n_r <= 1'b1;
          if (dur_l_r == {WIDTH{1'b0}}) begin
            // Zero-length interval: skip RUN, the counter is already 0.
            state_r  <= DONE;
            done_r   <= gnt_r;
            cnt_en_r <= 1'b0;
          end else begin
            state_r  <= RUN;
            cnt_en_r <= 1'b1;
          end
        end
        RUN: begin
          // Completion wins over a same-cycle request drop; >= tolerates overshoot.
          if (cnt_q >= dur_l_r) begin
            state_r  <= DONE;
            done_r   <= gnt_r;
            cnt_en_r <= 1'b0;
          end else if (!owner_req_s) begin
            state_r  <= IDLE;
            abort_r  <= 1'b1;
            gnt_r    <= 2'b00;
            busy_r   <= 1'b0;
            cnt_en_r <= 1'b0;
          end else begin
            state_r  <= RUN;
            cnt_en_r <= 1'b1;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          gnt_r       <= 2'b00;
          busy_r      <= 1'b0;
          cnt_en_r    <= 1'b0;
          cnt_clr_n_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= 2'b00;
          busy_r      <= 1'b0;
          cnt_en_r    <= 1'b0;
          cnt_clr_n_r <= 1'b1;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign abort     = abort_r;
  assign busy      = busy_r;
  assign cnt_en    = cnt_en_r;
  assign cnt_clr_n = cnt_clr_n_r;

  contador_arbitro_chk u_chk (
    .clk       (clk),
    .clr       (clr),
    .gnt       (gnt_r),
    .done      (done_r),
    .abort     (abort_r),
    .busy      (busy_r),
    .cnt_en    (cnt_en_r),
    .cnt_clr_n (cnt_clr_n_r)
  );

endmodule

// File: tb/tb_contador_arbitro.sv
// Directed testbench for contador_arbitro, including a behavioural model of
// the falling-edge counter it drives.
module tb_contador_arbitro;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] dur0 = 8'd0;
  logic [7:0] dur1 = 8'd0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       abort;
  logic       busy;
  logic       cnt_en;
  logic       cnt_clr_n;
  logic [7:0] cnt_q = 8'd0;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  contador_arbitro #(.WIDTH(8)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .dur0      (dur0),
    .dur1      (dur1),
    .gnt       (gnt),
    .done      (done),
    .abort     (abort),
    .busy      (busy),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .cnt_q     (cnt_q)
  );

  always #5 clk = ~clk;

  // Counter model: async active-low clear, counts on falling edge when enabled.
  always_ff @(negedge clk or negedge cnt_clr_n) begin
    if (!cnt_clr_n) cnt_q <= 8'd0;
    else if (cnt_en) cnt_q <= cnt_q + 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expects a grant to index idx on the next edge, then a full interval of d.
  task automatic serve(input int idx, input int d);
    int en_cnt;
    int cyc;
    int gnt_bad;
    logic [1:0] oh;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    en_cnt = 0;
    cyc = 0;
    gnt_bad = 0;
    tick();
    chk("grant_gnt", 32'(gnt), 32'(oh));
    chk("grant_clr_n", 32'(cnt_clr_n), 32'd0);
    chk("grant_busy", 32'(busy), 32'd1);
    chk("grant_abort", 32'(abort), 32'd0);
    tick();
    cyc = 1;
    while (done == 2'b00 && cyc < 300) begin
      if (cnt_en) en_cnt++;
      if (gnt != oh) gnt_bad++;
      tick();
      cyc++;
    end
    chk("done_val", 32'(done), 32'(oh));
    chk("done_latency", cyc, d + 1);
    chk("en_cycles", en_cnt, d);
    chk("done_cnt_q", 32'(cnt_q), d);
    chk("done_gnt", 32'(gnt), 32'(oh));
    chk("done_en", 32'(cnt_en), 32'd0);
    chk("gnt_stable", gnt_bad, 32'd0);
  endtask

  initial begin
    // Reset state
    #1 clr = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(cnt_en), 32'd0);
    chk("rst_clr_n", 32'(cnt_clr_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk) clr = 1'b0;
    tick();
    chk("rel_clr_n", 32'(cnt_clr_n), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);

    // Single request, dur0 = 5
    dur0 = 8'd5;
    req = 2'b01;
    serve(0, 5);
    req = 2'b00;
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_gnt", 32'(gnt), 32'd0);
    chk("t1_idle_done", 32'(done), 32'd0);

    // Fresh reset, then round robin with both requests held
    #1 clr = 1'b1;
    #1 chk("rst2_gnt", 32'(gnt), 32'd0);
    @(negedge clk) clr = 1'b0;
    tick();
    dur0 = 8'd3;
    dur1 = 8'd4;
    req = 2'b11;
    serve(0, 3);
    tick();
    chk("rr_gap1", 32'(busy), 32'd0);
    serve(1, 4);
    tick();
    chk("rr_gap2", 32'(gnt), 32'd0);
    serve(0, 3);
    tick();
    serve(1, 4);
    req = 2'b00;
    tick();

    // Zero-length interval on requester 1
    dur1 = 8'd0;
    req = 2'b10;
    serve(1, 0);
    req = 2'b00;
    tick();

    // Abort after 10 RUN cycles with requester 1 pending
    dur0 = 8'd200;
    req = 2'b11;
    tick();
    chk("ab_gnt", 32'(gnt), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ab_run_en", 32'(cnt_en), 32'd1);
    end
    chk("ab_cnt_q", 32'(cnt_q), 32'd9);
    req = 2'b10;
    tick();
    chk("ab_pulse", 32'(abort), 32'd1);
    chk("ab_no_done", 32'(done), 32'd0);
    chk("ab_en_off", 32'(cnt_en), 32'd0);
    chk("ab_gnt_off", 32'(gnt), 32'd0);
    serve(1, 0);
    req = 2'b00;
    tick();
    chk("ab_once", 32'(abort), 32'd0);

    // Reset mid-RUN with dur0 = 255
    dur0 = 8'd255;
    req = 2'b01;
    tick();
    for (int i = 0; i < 20; i++) tick();
    chk("mr_running", 32'(cnt_en), 32'd1);
    #1 clr = 1'b1;
    #1;
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_en", 32'(cnt_en), 32'd0);
    chk("mr_clr_n", 32'(cnt_clr_n), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_abort", 32'(abort), 32'd0);
    chk("mr_cnt_q", 32'(cnt_q), 32'd0);
    req = 2'b00;
    tick();
    tick();
    @(negedge clk) clr = 1'b0;
    tick();
    chk("mr_rel_clr_n", 32'(cnt_clr_n), 32'd1);

    // Tie after reset goes to 0; full 255 range with no wrap
    dur1 = 8'd4;
    req = 2'b11;
    serve(0, 255);
    req = 2'b00;
    tick();
    chk("full_hold_q", 32'(cnt_q), 32'd255);
    chk("full_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
